// File: rtl/md_pkg.sv
// md_pkg: operation encodings, FSM state encoding and small decode helpers
// shared by the multiply/divide unit and its arithmetic core.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for the multiply flavours (they use the multiply latency).
    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    // True for the operations that run multi-cycle and commit through the FSM.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide core. Produces {hi, lo} for the
// latched operands and flags a zero divisor so the caller can skip the commit.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [2:0]         op_i,
    output logic [2*WIDTH-1:0] hilo_o,
    output logic               div_by_zero_o
);

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    // Signed division works on magnitudes and fixes signs afterwards; this
    // makes MIN / -1 wrap naturally to LO = MIN, HI = 0.
    always_comb begin
        hilo_o        = {(2*WIDTH){1'b0}};
        div_by_zero_o = 1'b0;
        a_neg_s       = a_i[WIDTH-1];
        b_neg_s       = b_i[WIDTH-1];
        a_mag_s       = a_i[WIDTH-1] ? -a_i : a_i;
        b_mag_s       = b_i[WIDTH-1] ? -b_i : b_i;
        quo_s         = {WIDTH{1'b0}};
        rem_s         = {WIDTH{1'b0}};
        case (op_i)
            MD_MULT: begin
                hilo_o = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
            end
            MD_MULTU: begin
                hilo_o = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
            end
            MD_DIV: begin
                if (b_i == {WIDTH{1'b0}}) begin
                    div_by_zero_o = 1'b1;
                end else begin
                    quo_s  = a_mag_s / b_mag_s;
                    rem_s  = a_mag_s % b_mag_s;
                    hilo_o = {(a_neg_s ? -rem_s : rem_s),
                              ((a_neg_s ^ b_neg_s) ? -quo_s : quo_s)};
                end
            end
            MD_DIVU: begin
                if (b_i == {WIDTH{1'b0}}) begin
                    div_by_zero_o = 1'b1;
                end else begin
                    quo_s  = a_i / b_i;
                    rem_s  = a_i % b_i;
                    hilo_o = {rem_s, quo_s};
                end
            end
            default: begin
                hilo_o = {(2*WIDTH){1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers. Mult/div run for a
// fixed latency and commit on the edge that clears Busy; MTHI/MTLO write
// in one cycle. Starts while busy are ignored.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [2*WIDTH-1:0] hilo_s;
    logic               dbz_s;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .a_i           (a_q),
        .b_i           (b_q),
        .op_i          (op_q),
        .hilo_o        (hilo_s),
        .div_by_zero_o (dbz_s)
    );

    // Next-state: accept work when idle, count down while running, commit at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (is_muldiv(Op)) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = Op;
                        cnt_d   = is_mul(Op) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                        state_d = ST_RUN;
                    end else if (Op == MD_MTHI) begin
                        hi_d = A;
                    end else if (Op == MD_MTLO) begin
                        lo_d = A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                    if (!dbz_s) begin
                        hi_d = hilo_s[2*WIDTH-1:WIDTH];
                        lo_d = hilo_s[WIDTH-1:0];
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State, operand, counter and HI/LO registers; async reset drops any pending result.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            op_q    <= MD_MULT;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random stimulus against two md_unit instances
// (default latencies and MULT_LAT=DIV_LAT=1) with an arithmetic reference model.
module tb_md_unit;
    import md_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start_s [2];
    logic [2:0]  op_s    [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];
    logic        busy_s  [2];
    logic [31:0] hi_s    [2];
    logic [31:0] lo_s    [2];

    logic [31:0] hi_m [2];
    logic [31:0] lo_m [2];
    int          mult_lat [2] = '{5, 1};
    int          div_lat  [2] = '{10, 1};

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut0 (
        .Clk(Clk), .Rst(Rst), .Start(start_s[0]), .Op(op_s[0]), .A(a_s[0]), .B(b_s[0]),
        .Busy(busy_s[0]), .HI(hi_s[0]), .LO(lo_s[0])
    );

    md_unit #(.WIDTH(32), .MULT_LAT(1), .DIV_LAT(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .Start(start_s[1]), .Op(op_s[1]), .A(a_s[1]), .B(b_s[1]),
        .Busy(busy_s[1]), .HI(hi_s[1]), .LO(lo_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: apply the architectural effect of one accepted op to HI/LO.
    task automatic model(input int d, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 0;
        case (op)
            MD_MULT:  begin p = sa * sb; hi_m[d] = p[63:32]; lo_m[d] = p[31:0]; lat = mult_lat[d]; end
            MD_MULTU: begin p = {32'h0, a} * {32'h0, b}; hi_m[d] = p[63:32]; lo_m[d] = p[31:0]; lat = mult_lat[d]; end
            MD_DIV: begin
                lat = div_lat[d];
                if (b != 32'h0) begin
                    q = sa / sb; r = sa % sb;
                    p = q; lo_m[d] = p[31:0];
                    p = r; hi_m[d] = p[31:0];
                end
            end
            MD_DIVU: begin
                lat = div_lat[d];
                if (b != 32'h0) begin lo_m[d] = a / b; hi_m[d] = a % b; end
            end
            MD_MTHI: hi_m[d] = a;
            MD_MTLO: lo_m[d] = a;
            default: lat = 0;
        endcase
    endtask

    // Issue one op in the current cycle (caller sits just after a negedge),
    // measure the Busy width, then check HI/LO against the model.
    task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        int          n, exp_lat;
        logic [31:0] old_hi, old_lo;
        old_hi = hi_m[d];
        old_lo = lo_m[d];
        model(d, op, a, b, exp_lat);
        start_s[d] = 1'b1; op_s[d] = op; a_s[d] = a; b_s[d] = b;
        @(negedge Clk);
        start_s[d] = 1'b0; a_s[d] = $urandom; b_s[d] = $urandom; op_s[d] = 3'($urandom_range(0, 5));
        n = 0;
        while (busy_s[d] === 1'b1 && n < 200) begin
            if (n == 0) begin
                chk({tag, " hi hidden"}, hi_s[d], old_hi);
                chk({tag, " lo hidden"}, lo_s[d], old_lo);
            end
            n++;
            @(negedge Clk);
        end
        chk({tag, " busy cycles"}, 32'(n), 32'(exp_lat));
        chk({tag, " hi"}, hi_s[d], hi_m[d]);
        chk({tag, " lo"}, lo_s[d], lo_m[d]);
    endtask

    initial begin
        int          lat, n;
        logic [2:0]  op;
        logic [31:0] a, b;

        Rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; op_s[d] = MD_MULT; a_s[d] = 32'h0; b_s[d] = 32'h0;
            hi_m[d] = 32'h0; lo_m[d] = 32'h0;
        end
        #12;
        chk("reset busy", 32'(busy_s[0]), 32'h0);
        chk("reset hi", hi_s[0], 32'h0);
        chk("reset lo", lo_s[0], 32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        issue(0, MD_MULT, 32'hFFFFFFFE, 32'd3, "mult");
        chk("mult hi const", hi_s[0], 32'hFFFFFFFF);
        chk("mult lo const", lo_s[0], 32'hFFFFFFFA);
        issue(0, MD_MULTU, 32'hFFFFFFFE, 32'd3, "multu");
        chk("multu hi const", hi_s[0], 32'h00000002);
        issue(0, MD_DIV, 32'hFFFFFFF9, 32'd2, "div");
        chk("div lo const", lo_s[0], 32'hFFFFFFFD);
        chk("div hi const", hi_s[0], 32'hFFFFFFFF);
        issue(0, MD_DIVU, 32'd7, 32'd2, "divu");
        chk("divu lo const", lo_s[0], 32'd3);
        chk("divu hi const", hi_s[0], 32'd1);
        issue(0, MD_MTHI, 32'h12345678, 32'h0, "mthi");
        chk("mthi const", hi_s[0], 32'h12345678);

        // MTLO issued while a MULT is running must be dropped.
        model(0, MD_MULT, 32'd5, 32'd7, lat);
        start_s[0] = 1'b1; op_s[0] = MD_MULT; a_s[0] = 32'd5; b_s[0] = 32'd7;
        @(negedge Clk);
        start_s[0] = 1'b1; op_s[0] = MD_MTLO; a_s[0] = 32'hDEADBEEF;
        @(negedge Clk);
        start_s[0] = 1'b0;
        chk("mtlo busy lo", lo_s[0], 32'h3);
        n = 1;
        while (busy_s[0] === 1'b1 && n < 200) begin n++; @(negedge Clk); end
        chk("mtlo busy cycles", 32'(n), 32'(lat));
        chk("mtlo busy hi", hi_s[0], 32'h0);
        chk("mtlo busy lo after", lo_s[0], 32'd35);

        issue(0, MD_MTHI, 32'hAA, 32'h0, "set hi");
        issue(0, MD_MTLO, 32'hBB, 32'h0, "set lo");
        issue(0, MD_DIV, 32'h1234, 32'h0, "div0");
        chk("div0 hi const", hi_s[0], 32'hAA);
        chk("div0 lo const", lo_s[0], 32'hBB);
        issue(0, MD_DIVU, 32'h5678, 32'h0, "divu0");
        issue(0, MD_DIV, 32'h80000000, 32'hFFFFFFFF, "divovf");
        chk("divovf lo const", lo_s[0], 32'h80000000);
        chk("divovf hi const", hi_s[0], 32'h0);

        for (int i = 0; i < 25; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 9);
                default: b = b;
            endcase
            issue(0, op, a, b, "rand0");
        end

        // Latency-1 instance: every issue starts two cycles after the last.
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            issue(1, op, a, b, "rand1");
        end

        // Asynchronous reset in the third busy cycle of a MULT.
        issue(0, MD_MTHI, 32'hCAFE0001, 32'h0, "pre hi");
        issue(0, MD_MTLO, 32'hCAFE0002, 32'h0, "pre lo");
        start_s[0] = 1'b1; op_s[0] = MD_MULT; a_s[0] = 32'd9; b_s[0] = 32'd9;
        @(negedge Clk);
        start_s[0] = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst busy before", 32'(busy_s[0]), 32'h1);
        #1 Rst = 1'b0;
        #1;
        chk("rst busy", 32'(busy_s[0]), 32'h0);
        chk("rst hi", hi_s[0], 32'h0);
        chk("rst lo", lo_s[0], 32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (8) @(negedge Clk);
        chk("post rst busy", 32'(busy_s[0]), 32'h0);
        chk("post rst hi", hi_s[0], 32'h0);
        chk("post rst lo", lo_s[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
